// File: rtl/stack_pkg.sv
// Shared encodings, FSM states and geometry for the two-port stack arbiter.
package stack_pkg;
  localparam int DEPTH = 5;
  localparam int DW    = 4;
  localparam int IW    = 3;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_RD1,
    ST_RD2,
    ST_POPADV,
    ST_DONE
  } state_t;
endpackage

// File: rtl/stack_port_arbiter_if.sv
// Requester-side handshake bundle: two requesters packed side by side.
interface stack_port_arbiter_if;
  import stack_pkg::*;

  logic [1:0]    REQ;
  logic [3:0]    REQ_CMD;
  logic [5:0]    REQ_IDX;
  logic [7:0]    REQ_WDATA;
  logic [1:0]    ACK;
  logic [DW-1:0] RDATA;
  logic          ERR;

  modport master (output REQ, REQ_CMD, REQ_IDX, REQ_WDATA, input ACK, RDATA, ERR);
  modport slave  (input REQ, REQ_CMD, REQ_IDX, REQ_WDATA, output ACK, RDATA, ERR);
endinterface

// File: rtl/stack_port_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer remembers which requester won last.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] REQ,
  input  logic       ADVANCE,
  output logic [1:0] GRANT
);
  logic last;

  always_comb begin
    GRANT = 2'b00;
    case (REQ)
      2'b01:   GRANT = 2'b01;
      2'b10:   GRANT = 2'b10;
      2'b11:   GRANT = last ? 2'b01 : 2'b10;
      default: GRANT = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     last <= 1'b0;
    else if (ADVANCE) last <= GRANT[1];
  end
endmodule

// File: rtl/stack_port_arbiter.sv
// Arbitrates two requesters onto a 5-entry bidirectional-bus stack and
// sequences legal COMMAND/INDEX/IO_DATA cycles, filtering illegal requests.
module stack_port_arbiter
  import stack_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_N,
  stack_port_arbiter_if.slave  port,
  output logic [1:0]           STK_CMD,
  output logic [IW-1:0]        STK_IDX,
  inout  wire  [DW-1:0]        STK_DATA,
  output logic                 STK_RESET,
  output logic [2:0]           COUNT,
  output logic                 FULL,
  output logic                 EMPTY
);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_t        state, state_nxt;
  logic [1:0]    grant, gnt_q;
  logic          advance, chk_err, err_q, drive;
  logic [1:0]    sel_cmd, cmd_q;
  logic [IW-1:0] sel_idx, idx_q;
  logic [DW-1:0] sel_wdata, wdata_q, cap_q;

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (port.REQ),
    .ADVANCE (advance),
    .GRANT   (grant)
  );

  assign advance   = (state == ST_IDLE) && (grant != 2'b00);
  assign sel_cmd   = grant[1] ? port.REQ_CMD[3:2]   : port.REQ_CMD[1:0];
  assign sel_idx   = grant[1] ? port.REQ_IDX[5:3]   : port.REQ_IDX[2:0];
  assign sel_wdata = grant[1] ? port.REQ_WDATA[7:4] : port.REQ_WDATA[3:0];

  assign FULL  = (COUNT == DEPTH_C);
  assign EMPTY = (COUNT == 3'd0);

  // Illegal requests never reach the stack, so its pointer cannot wrap.
  assign chk_err = (sel_cmd == CMD_NOP) ||
                   ((sel_cmd == CMD_PUSH) && FULL) ||
                   ((sel_cmd == CMD_POP) && EMPTY) ||
                   ((sel_cmd == CMD_GET) && (sel_idx >= COUNT));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      gnt_q <= 2'b00;
      err_q <= 1'b0;
      COUNT <= 3'd0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        gnt_q <= grant;
        err_q <= chk_err;
      end
      if (state == ST_PUSH)        COUNT <= COUNT + 3'd1;
      else if (state == ST_POPADV) COUNT <= COUNT - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (advance) begin
      cmd_q   <= sel_cmd;
      idx_q   <= (sel_cmd == CMD_POP) ? '0 : sel_idx;
      wdata_q <= sel_wdata;
    end
  end

  // The stack drives the selected entry in the high phase of RD2.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N)             cap_q <= '0;
    else if (state == ST_RD2) cap_q <= STK_DATA;
  end

  always_comb begin
    state_nxt = state;
    STK_CMD   = CMD_NOP;
    STK_IDX   = '0;
    drive     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (advance) begin
          if (chk_err)                   state_nxt = ST_DONE;
          else if (sel_cmd == CMD_PUSH)  state_nxt = ST_PUSH;
          else                           state_nxt = ST_RD1;
        end
      end
      ST_PUSH: begin
        STK_CMD   = CMD_PUSH;
        drive     = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_RD1: begin
        STK_CMD   = CMD_GET;
        STK_IDX   = idx_q;
        state_nxt = ST_RD2;
      end
      ST_RD2: begin
        STK_CMD   = CMD_GET;
        STK_IDX   = idx_q;
        state_nxt = (cmd_q == CMD_POP) ? ST_POPADV : ST_DONE;
      end
      ST_POPADV: begin
        STK_CMD   = CMD_POP;
        state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign STK_DATA   = drive ? wdata_q : {DW{1'bz}};
  assign STK_RESET  = !RESET_N;
  assign port.ACK   = (state == ST_DONE) ? gnt_q : 2'b00;
  assign port.ERR   = (state == ST_DONE) && err_q;
  assign port.RDATA = ((state == ST_DONE) && !err_q && (cmd_q != CMD_PUSH)) ? cap_q : '0;
endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed bench for stack_port_arbiter with a behavioural stack on the shared bus.
module tb_stack_port_arbiter;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [3:0] stk_data;
  logic [1:0] stk_cmd;
  logic [2:0] stk_idx;
  logic       stk_reset;
  logic [2:0] count;
  logic       full, empty;

  stack_port_arbiter_if bus ();

  stack_port_arbiter dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .port      (bus),
    .STK_CMD   (stk_cmd),
    .STK_IDX   (stk_idx),
    .STK_DATA  (stk_data),
    .STK_RESET (stk_reset),
    .COUNT     (count),
    .FULL      (full),
    .EMPTY     (empty)
  );

  // An undriven bus floats to all ones so a stray controller drive is visible.
  pullup (stk_data[0]);
  pullup (stk_data[1]);
  pullup (stk_data[2]);
  pullup (stk_data[3]);

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural stack: index 0 is the top entry.
  logic [3:0] mem [0:4];
  int         sp = 0;
  int         push_cnt = 0;
  logic [3:0] rd_val;

  always @(posedge clk or posedge stk_reset) begin
    if (stk_reset) sp <= 0;
    else begin
      if (stk_cmd == 2'b01) begin
        push_cnt <= push_cnt + 1;
        if (sp < 5) begin
          mem[sp] <= stk_data;
          sp      <= sp + 1;
        end
      end else if (stk_cmd == 2'b10 && sp > 0) sp <= sp - 1;
    end
  end

  always_comb begin
    rd_val = 4'h0;
    if (int'(stk_idx) < sp) rd_val = mem[sp - 1 - int'(stk_idx)];
  end

  assign stk_data = (stk_cmd == 2'b11) ? rd_val : 4'bzzzz;

  typedef struct {
    int         r;
    logic [3:0] rdata;
    logic       err;
    logic [2:0] cnt;
    int         lat;
  } exp_t;

  exp_t       sbq [$];
  logic [1:0] cmd_log [$];
  int         age [2];

  always @(posedge clk) begin
    for (int r = 0; r < 2; r++) age[r] <= bus.REQ[r] ? age[r] + 1 : 0;
  end

  always @(negedge clk) begin
    if (stk_cmd != 2'b00) cmd_log.push_back(stk_cmd);
    if (stk_cmd != 2'b11 && stk_cmd != 2'b01) check("bus_released", stk_data, 4'hF);
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.ACK != 2'b00) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got %0b, expected none at %0t", bus.ACK, $time);
      end else begin
        e = sbq.pop_front();
        check("ack_id", bus.ACK, 32'(2'b01 << e.r));
        check("rdata", bus.RDATA, e.rdata);
        check("err", bus.ERR, e.err);
        check("count", count, e.cnt);
        if (e.lat > 0) check("latency", age[e.r], e.lat);
      end
    end
  end

  task automatic txn(input int r, input logic [1:0] cmd, input logic [2:0] idx,
                     input logic [3:0] wd, input logic [3:0] er, input logic ee,
                     input logic [2:0] ec, input int lat, input bit push_exp);
    int n;
    exp_t e;
    if (push_exp) begin
      e = '{r, er, ee, ec, lat};
      sbq.push_back(e);
    end
    bus.REQ_CMD[2*r +: 2]   = cmd;
    bus.REQ_IDX[3*r +: 3]   = idx;
    bus.REQ_WDATA[4*r +: 4] = wd;
    bus.REQ[r]              = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ACK[r] && n < 40);
    if (!bus.ACK[r]) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack, expected one within 40 cycles", r);
    end
    @(posedge clk); #1;
    bus.REQ[r] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    exp_t e;
    bus.REQ = 2'b00; bus.REQ_CMD = '0; bus.REQ_IDX = '0; bus.REQ_WDATA = '0;
    #1 check("stk_reset_low", stk_reset, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count, 3'd0);
    check("rst_ack", bus.ACK, 2'b00);
    check("rst_err", bus.ERR, 1'b0);
    check("rst_rdata", bus.RDATA, 4'h0);
    check("rst_cmd", stk_cmd, 2'b00);
    check("rst_idx", stk_idx, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    rst_n = 1'b1;
    #1 check("stk_reset_high", stk_reset, 1'b0);
    @(posedge clk); #1;

    // r, cmd, idx, wdata, exp rdata, exp err, exp count, latency
    txn(0, CMD_PUSH, 3'd0, 4'h3, 4'h0, 1'b0, 3'd1, 2, 1'b1);
    txn(0, CMD_PUSH, 3'd0, 4'h9, 4'h0, 1'b0, 3'd2, 2, 1'b1);
    txn(0, CMD_GET,  3'd1, 4'h0, 4'h3, 1'b0, 3'd2, 3, 1'b1);
    cmd_log.delete();
    txn(0, CMD_POP,  3'd0, 4'h0, 4'h9, 1'b0, 3'd1, 4, 1'b1);
    check("pop_cmd_len", cmd_log.size(), 3);
    check("pop_cmd_seq", {cmd_log[0], cmd_log[1], cmd_log[2]}, 6'b111110);

    // A was served last, so B must win the tie.
    e = '{1, 4'h0, 1'b0, 3'd2, 0}; sbq.push_back(e);
    e = '{0, 4'h0, 1'b0, 3'd3, 0}; sbq.push_back(e);
    fork
      txn(0, CMD_PUSH, 3'd0, 4'h1, 4'h0, 1'b0, 3'd3, 0, 1'b0);
      txn(1, CMD_PUSH, 3'd0, 4'h2, 4'h0, 1'b0, 3'd2, 0, 1'b0);
    join
    txn(0, CMD_GET, 3'd0, 4'h0, 4'h1, 1'b0, 3'd3, 3, 1'b1);
    txn(0, CMD_POP, 3'd0, 4'h0, 4'h1, 1'b0, 3'd2, 4, 1'b1);
    txn(1, CMD_POP, 3'd0, 4'h0, 4'h2, 1'b0, 3'd1, 4, 1'b1);
    txn(0, CMD_POP, 3'd0, 4'h0, 4'h3, 1'b0, 3'd0, 4, 1'b1);

    for (int i = 1; i <= 5; i++)
      txn(0, CMD_PUSH, 3'd0, 4'(i), 4'h0, 1'b0, 3'(i), 2, 1'b1);
    check("full_at_5", full, 1'b1);
    pc = push_cnt;
    cmd_log.delete();
    txn(0, CMD_PUSH, 3'd0, 4'h6, 4'h0, 1'b1, 3'd5, 1, 1'b1);
    check("overflow_no_push", push_cnt, pc);
    check("overflow_no_cmd", cmd_log.size(), 0);
    txn(0, CMD_GET, 3'd4, 4'h0, 4'h1, 1'b0, 3'd5, 3, 1'b1);
    txn(1, CMD_GET, 3'd5, 4'h0, 4'h0, 1'b1, 3'd5, 1, 1'b1);
    for (int i = 0; i < 5; i++)
      txn(0, CMD_POP, 3'd0, 4'h0, 4'(5 - i), 1'b0, 3'(4 - i), 4, 1'b1);
    check("empty_after_pops", empty, 1'b1);
    txn(0, CMD_POP, 3'd0, 4'h0, 4'h0, 1'b1, 3'd0, 1, 1'b1);
    txn(1, CMD_GET, 3'd0, 4'h0, 4'h0, 1'b1, 3'd0, 1, 1'b1);

    txn(0, CMD_PUSH, 3'd0, 4'h7, 4'h0, 1'b0, 3'd1, 2, 1'b1);
    txn(1, CMD_PUSH, 3'd0, 4'h8, 4'h0, 1'b0, 3'd2, 2, 1'b1);
    txn(0, CMD_GET,  3'd3, 4'h0, 4'h0, 1'b1, 3'd2, 1, 1'b1);
    txn(0, CMD_GET,  3'd2, 4'h0, 4'h0, 1'b1, 3'd2, 1, 1'b1);
    txn(1, CMD_NOP,  3'd0, 4'h0, 4'h0, 1'b1, 3'd2, 1, 1'b1);
    txn(1, CMD_GET,  3'd1, 4'h0, 4'h7, 1'b0, 3'd2, 3, 1'b1);

    // Reset lands in RD2 of a GET; the transaction must vanish without an ACK.
    bus.REQ_CMD[3:2] = CMD_GET;
    bus.REQ_IDX[5:3] = 3'd1;
    bus.REQ[1]       = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("rd2_cmd", stk_cmd, 2'b11);
    rst_n      = 1'b0;
    bus.REQ[1] = 1'b0;
    #1;
    check("midrst_stk_reset", stk_reset, 1'b1);
    check("midrst_count", count, 3'd0);
    check("midrst_ack", bus.ACK, 2'b00);
    check("midrst_cmd", stk_cmd, 2'b00);
    check("midrst_bus", stk_data, 4'hF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, CMD_GET, 3'd0, 4'h0, 4'h0, 1'b1, 3'd0, 1, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
